uart_tx_feeder: RTL

- Byte buffer and transmit sequencer directly upstream of the UART transmitter.
- Accepts bytes from the SoC side in the system clock domain and stores them in a FIFO.
- Presents one byte at a time on the transmitter's data/start inputs and pops the next byte only after the transmitter's done indication, synchronised from the slower baud-clock domain.
- Flags overflow, transmitter errors and missing-done timeouts.

---
 rtl/uart_pkg.sv | 21 ++
 rtl/uart_sync_fifo.sv | 68 ++++++
 rtl/uart_tx_feeder.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmit path.
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        LOAD     = 2'd1,
        START    = 2'd2,
        WAIT_LOW = 2'd3
    } feeder_state_t;

    localparam int UART_WIDTH = 8;

    // Budget `frames` 10-bit frames (start + 8 data + stop) before a byte is abandoned.
    function automatic int unsigned calc_timeout_cycles(input int unsigned clk_hz,
                                                        input int unsigned baud,
                                                        input int unsigned frames);
        if (baud == 0) return 0;
        return (clk_hz / baud) * 10 * frames;
    endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// Single-clock circular FIFO with registered full/empty/level flags.
module uart_sync_fifo
    import uart_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int WIDTH = UART_WIDTH
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       wr_en_i,
    input  logic [WIDTH-1:0]           wr_data_i,
    input  logic                       rd_en_i,
    output logic [WIDTH-1:0]           rd_data_o,
    output logic                       full_o,
    output logic                       empty_o,
    output logic [$clog2(DEPTH):0]     level_o,
    output logic                       drop_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam logic [LW-1:0] FULL_LVL = LW'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [LW-1:0]    level_q, level_d;
    logic             full_q, empty_q;
    logic             wr_acc, rd_acc;

    // A write into a full FIFO is dropped even if a pop frees a slot this cycle.
    assign wr_acc = wr_en_i & ~full_q;
    assign rd_acc = rd_en_i & ~empty_q;

    always_comb begin
        level_d = level_q;
        if (wr_acc && !rd_acc)
            level_d = level_q + 1'b1;
        else if (!wr_acc && rd_acc)
            level_d = level_q - 1'b1;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
        end else begin
            if (wr_acc) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (rd_acc) rd_ptr_q <= rd_ptr_q + 1'b1;
            level_q <= level_d;
            full_q  <= (level_d == FULL_LVL);
            empty_q <= (level_d == '0);
        end
    end

    always_ff @(posedge clk_i) begin
        if (wr_acc) mem_q[wr_ptr_q] <= wr_data_i;
    end

    assign rd_data_o = mem_q[rd_ptr_q];
    assign full_o    = full_q;
    assign empty_o   = empty_q;
    assign level_o   = level_q;
    assign drop_o    = wr_en_i & full_q;

endmodule

// File: rtl/uart_tx_feeder.sv
// Buffers SoC bytes and hands them one at a time to the baud-domain transmitter,
// advancing only on a synchronised done edge.
module uart_tx_feeder
    import uart_pkg::*;
#(
    parameter int          DEPTH          = 16,
    parameter int          WIDTH          = UART_WIDTH,
    parameter int          SYNC_STAGES    = 2,
    parameter int unsigned TIMEOUT_CYCLES = 2_000_000
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       wr_en_i,
    input  logic [WIDTH-1:0]           wr_data_i,
    output logic                       full_o,
    output logic                       empty_o,
    output logic [$clog2(DEPTH):0]     level_o,
    output logic [WIDTH-1:0]           tx_data_o,
    output logic                       tx_start_o,
    input  logic                       tx_done_i,
    input  logic                       tx_err_i,
    output logic                       busy_o,
    output logic                       overflow_o,
    output logic                       tx_err_o,
    output logic                       timeout_o,
    input  logic                       clr_err_i
);

    localparam bit          TO_EN   = (TIMEOUT_CYCLES != 0);
    localparam logic [31:0] TO_LAST = TO_EN ? 32'(TIMEOUT_CYCLES - 1) : 32'd0;

    feeder_state_t    state_q, state_d;
    logic [WIDTH-1:0] data_q, data_d, head;
    logic [31:0]      cnt_q, cnt_d;
    logic             start_q, start_d;
    logic             overflow_q, tx_err_q, timeout_q;
    logic             pop, set_err, set_to, fifo_drop;
    logic             done_s, err_s, done_s_q, done_rise;

    logic [SYNC_STAGES:0] done_chain, err_chain;
    assign done_chain[0] = tx_done_i;
    assign err_chain[0]  = tx_err_i;

    for (genvar g = 0; g < SYNC_STAGES; g++) begin : g_sync
        logic done_q, err_q;
        always_ff @(posedge clk_i or posedge rst_i) begin
            if (rst_i) begin
                done_q <= 1'b0;
                err_q  <= 1'b0;
            end else begin
                done_q <= done_chain[g];
                err_q  <= err_chain[g];
            end
        end
        assign done_chain[g+1] = done_q;
        assign err_chain[g+1]  = err_q;
    end

    assign done_s    = done_chain[SYNC_STAGES];
    assign err_s     = err_chain[SYNC_STAGES];
    assign done_rise = done_s & ~done_s_q;

    uart_sync_fifo #(.DEPTH(DEPTH), .WIDTH(WIDTH)) u_fifo (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .wr_en_i   (wr_en_i),
        .wr_data_i (wr_data_i),
        .rd_en_i   (pop),
        .rd_data_o (head),
        .full_o    (full_o),
        .empty_o   (empty_o),
        .level_o   (level_o),
        .drop_o    (fifo_drop)
    );

    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        cnt_d   = cnt_q;
        start_d = start_q;
        pop     = 1'b0;
        set_err = 1'b0;
        set_to  = 1'b0;
        case (state_q)
            IDLE: if (!empty_o) state_d = LOAD;
            LOAD: begin
                data_d  = head;
                pop     = 1'b1;
                cnt_d   = '0;
                start_d = 1'b1;
                state_d = START;
            end
            START: begin
                cnt_d = cnt_q + 1'b1;
                if (done_rise) begin
                    start_d = 1'b0;
                    set_err = err_s;
                    state_d = WAIT_LOW;
                end else if (TO_EN && cnt_q == TO_LAST) begin
                    start_d = 1'b0;
                    set_to  = 1'b1;
                    state_d = WAIT_LOW;
                end
            end
            // Hold off until done drops so a stuck-high done cannot launch the next byte.
            WAIT_LOW: if (!done_s) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= IDLE;
            data_q     <= '0;
            cnt_q      <= '0;
            start_q    <= 1'b0;
            done_s_q   <= 1'b0;
            overflow_q <= 1'b0;
            tx_err_q   <= 1'b0;
            timeout_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            data_q     <= data_d;
            cnt_q      <= cnt_d;
            start_q    <= start_d;
            done_s_q   <= done_s;
            overflow_q <= fifo_drop | (overflow_q & ~clr_err_i);
            tx_err_q   <= set_err   | (tx_err_q   & ~clr_err_i);
            timeout_q  <= set_to    | (timeout_q  & ~clr_err_i);
        end
    end

    assign tx_data_o  = data_q;
    assign tx_start_o = start_q;
    assign busy_o     = (state_q != IDLE);
    assign overflow_o = overflow_q;
    assign tx_err_o   = tx_err_q;
    assign timeout_o  = timeout_q;

endmodule
